traffic_light_monitor: RTL and testbench

- Passive observer on the six lamp outputs and emergency input of the traffic light controller: the receiving end of the lamp interface.
- Decodes the lamp pattern into a phase, tracks phase sequence and dwell time, and flags safety, sequence and timing violations.
- Sits beside the controller in the intersection top level and in benches; feeds the fault/status register block. Never drives lamps.

---
 rtl/traffic_light_monitor.sv | 172 +++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive observer of the traffic light lamp interface.
// Decodes the six lamps into a phase, tracks how long each phase is held
// and raises sticky flags for safety, sequence and timing violations.
module traffic_light_monitor #(
  parameter int GREEN_MIN  = 8,
  parameter int YELLOW_MIN = 3,
  parameter int MAX_DWELL  = 64,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ns_red,
  input  logic             ns_yellow,
  input  logic             ns_green,
  input  logic             ew_red,
  input  logic             ew_yellow,
  input  logic             ew_green,
  input  logic             emergency_vehicle,
  input  logic             clr_err,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic [CNT_W-1:0] rounds,
  output logic             err_conflict,
  output logic             err_lamp,
  output logic             err_seq,
  output logic             err_short,
  output logic             err_stuck,
  output logic [2:0]       err_first,
  output logic             viol
);

  typedef enum logic [2:0] {
    PH_ALL_RED    = 3'd0,
    PH_NS_GO      = 3'd1,
    PH_NS_CAUTION = 3'd2,
    PH_EW_GO      = 3'd3,
    PH_EW_CAUTION = 3'd4,
    PH_INVALID    = 3'd7
  } phase_t;

  localparam logic [CNT_W-1:0] ONE        = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] GREEN_LIM  = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] YELLOW_LIM = CNT_W'(YELLOW_MIN);
  localparam logic [CNT_W-1:0] STUCK_AT   = CNT_W'(MAX_DWELL - 1);

  phase_t           cur_q;
  phase_t           dec;
  logic [CNT_W-1:0] dwell_q;
  logic [CNT_W-1:0] rounds_q;
  logic             em_d1;
  logic             em_d2;
  logic             em_win;
  logic             stuck_done;
  logic             ns_bad;
  logic             ew_bad;
  logic             changed;
  logic             legal;
  logic             c_conflict;
  logic             c_lamp;
  logic             c_seq;
  logic             c_short;
  logic             c_stuck;
  logic             any_viol;
  logic [2:0]       first_code;

  assign em_win  = em_d1 | em_d2;
  assign changed = (dec != cur_q);

  // Decode the lamp pattern into a phase; anything unsafe or malformed is INVALID
  always_comb begin
    dec    = PH_ALL_RED;
    ns_bad = !(({ns_red, ns_yellow, ns_green} == 3'b100) ||
               ({ns_red, ns_yellow, ns_green} == 3'b010) ||
               ({ns_red, ns_yellow, ns_green} == 3'b001));
    ew_bad = !(({ew_red, ew_yellow, ew_green} == 3'b100) ||
               ({ew_red, ew_yellow, ew_green} == 3'b010) ||
               ({ew_red, ew_yellow, ew_green} == 3'b001));
    if (ns_bad || ew_bad || (!ns_red && !ew_red)) begin
      dec = PH_INVALID;
    end else if (!ns_red) begin
      dec = ns_green ? PH_NS_GO : PH_NS_CAUTION;
    end else if (!ew_red) begin
      dec = ew_green ? PH_EW_GO : PH_EW_CAUTION;
    end
  end

  // Transition legality: the normal ring, plus emergency preemption shortcuts
  always_comb begin
    legal = 1'b0;
    case (cur_q)
      PH_ALL_RED:    legal = (dec == PH_NS_GO) || (dec == PH_EW_GO);
      PH_NS_GO:      legal = (dec == PH_NS_CAUTION);
      PH_NS_CAUTION: legal = (dec == PH_ALL_RED);
      PH_EW_GO:      legal = (dec == PH_EW_CAUTION);
      PH_EW_CAUTION: legal = (dec == PH_ALL_RED);
      default:       legal = 1'b0;
    endcase
    if (em_win && ((dec == PH_NS_GO) || (cur_q == PH_NS_GO && dec == PH_ALL_RED))) begin
      legal = 1'b1;
    end
  end

  // Evaluate all checks on this sample and pick the lowest code among new violations
  always_comb begin
    c_conflict = !ns_red && !ew_red;
    c_lamp     = ns_bad || ew_bad;
    c_seq      = changed && (dec != PH_INVALID) && (cur_q != PH_INVALID) && !legal;
    c_short    = changed && (dec != PH_INVALID) && !em_win &&
                 ((((cur_q == PH_NS_GO) || (cur_q == PH_EW_GO)) && (dwell_q < GREEN_LIM)) ||
                  (((cur_q == PH_NS_CAUTION) || (cur_q == PH_EW_CAUTION)) && (dwell_q < YELLOW_LIM)));
    c_stuck    = !changed && !emergency_vehicle && !stuck_done && (dwell_q >= STUCK_AT);
    any_viol   = c_conflict || c_lamp || c_seq || c_short || c_stuck;
    first_code = 3'd0;
    if (c_conflict)     first_code = 3'd1;
    else if (c_lamp)    first_code = 3'd2;
    else if (c_seq)     first_code = 3'd3;
    else if (c_short)   first_code = 3'd4;
    else if (c_stuck)   first_code = 3'd5;
  end

  // Phase, dwell, round counting and emergency history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q      <= PH_ALL_RED;
      dwell_q    <= ONE;
      rounds_q   <= '0;
      em_d1      <= 1'b0;
      em_d2      <= 1'b0;
      stuck_done <= 1'b0;
    end else begin
      cur_q <= dec;
      em_d1 <= emergency_vehicle;
      em_d2 <= em_d1;
      if (changed) begin
        dwell_q    <= ONE;
        stuck_done <= 1'b0;
      end else begin
        if (dwell_q != '1) dwell_q <= dwell_q + ONE;
        if (c_stuck) stuck_done <= 1'b1;
      end
      if (cur_q == PH_ALL_RED && dec == PH_NS_GO && !em_win) begin
        rounds_q <= rounds_q + ONE;
      end
    end
  end

  // Sticky flags, first-error capture and violation pulse; a new violation beats clr_err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_conflict <= 1'b0;
      err_lamp     <= 1'b0;
      err_seq      <= 1'b0;
      err_short    <= 1'b0;
      err_stuck    <= 1'b0;
      err_first    <= 3'd0;
      viol         <= 1'b0;
    end else begin
      err_conflict <= c_conflict || (err_conflict && !clr_err);
      err_lamp     <= c_lamp     || (err_lamp     && !clr_err);
      err_seq      <= c_seq      || (err_seq      && !clr_err);
      err_short    <= c_short    || (err_short    && !clr_err);
      err_stuck    <= c_stuck    || (err_stuck    && !clr_err);
      if (err_first == 3'd0 || clr_err) err_first <= first_code;
      viol <= any_viol;
    end
  end

  assign phase  = cur_q;
  assign dwell  = dwell_q;
  assign rounds = rounds_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: a behavioural model predicts
// every output for each driven sample, and directed checks pin down the
// key scenarios with literal expected values.
module tb_traffic_light_monitor;

  localparam int GREEN_MIN  = 8;
  localparam int YELLOW_MIN = 3;
  localparam int MAX_DWELL  = 64;
  localparam int CNT_W      = 8;

  // lamp vectors {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
  localparam logic [5:0] ALL_R  = 6'b100_100;
  localparam logic [5:0] NS_G   = 6'b001_100;
  localparam logic [5:0] NS_Y   = 6'b010_100;
  localparam logic [5:0] EW_G   = 6'b100_001;
  localparam logic [5:0] EW_Y   = 6'b100_010;
  localparam logic [5:0] BOTH_G = 6'b001_001;
  localparam logic [5:0] NS_RY  = 6'b110_100;

  typedef struct packed {
    logic [2:0] ph;
    logic [7:0] dw;
    logic [7:0] rd;
    logic [4:0] er;
    logic [2:0] fi;
    logic       vi;
  } exp_t;

  logic clk;
  logic rst_n;
  logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
  logic emergency_vehicle;
  logic clr_err;
  logic [2:0] phase;
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] rounds;
  logic err_conflict, err_lamp, err_seq, err_short, err_stuck;
  logic [2:0] err_first;
  logic viol;

  exp_t sb[$];
  int assert_cnt = 0;
  int fail_cnt = 0;

  // model state
  int m_phase, m_dwell, m_rounds, m_first;
  bit m_err[5];
  bit m_viol, m_em1, m_em2, m_stuck_done;

  traffic_light_monitor #(
    .GREEN_MIN(GREEN_MIN), .YELLOW_MIN(YELLOW_MIN), .MAX_DWELL(MAX_DWELL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .emergency_vehicle(emergency_vehicle), .clr_err(clr_err),
    .phase(phase), .dwell(dwell), .rounds(rounds),
    .err_conflict(err_conflict), .err_lamp(err_lamp), .err_seq(err_seq),
    .err_short(err_short), .err_stuck(err_stuck),
    .err_first(err_first), .viol(viol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] obsErrs();
    return {err_stuck, err_short, err_seq, err_lamp, err_conflict};
  endfunction

  function automatic bit legalMove(int from, int to, bit win);
    if (win && to == 1) return 1'b1;
    if (win && from == 1 && to == 0) return 1'b1;
    return (from == 0 && to == 1) || (from == 1 && to == 2) || (from == 2 && to == 0) ||
           (from == 0 && to == 3) || (from == 3 && to == 4) || (from == 4 && to == 0);
  endfunction

  function automatic exp_t modelSnapshot();
    exp_t e;
    e.ph = 3'(m_phase);
    e.dw = 8'(m_dwell);
    e.rd = 8'(m_rounds);
    e.er = {m_err[4], m_err[3], m_err[2], m_err[1], m_err[0]};
    e.fi = 3'(m_first);
    e.vi = m_viol;
    return e;
  endfunction

  task automatic modelReset();
    m_phase = 0; m_dwell = 1; m_rounds = 0; m_first = 0;
    foreach (m_err[i]) m_err[i] = 1'b0;
    m_viol = 0; m_em1 = 0; m_em2 = 0; m_stuck_done = 0;
  endtask

  // Advance the model by one clock edge with the given inputs
  task automatic modelStep(input logic [5:0] l, input bit em, input bit clr);
    int nsOn, ewOn, d, code;
    bit win, chg;
    bit v[5];
    nsOn = int'(l[5]) + int'(l[4]) + int'(l[3]);
    ewOn = int'(l[2]) + int'(l[1]) + int'(l[0]);
    v[0] = !l[5] && !l[2];
    v[1] = (nsOn != 1) || (ewOn != 1);
    if (v[0] || v[1]) d = 7;
    else if (!l[5]) d = l[3] ? 1 : 2;
    else if (!l[2]) d = l[0] ? 3 : 4;
    else d = 0;
    win = m_em1 || m_em2;
    chg = (d != m_phase);
    v[2] = chg && d != 7 && m_phase != 7 && !legalMove(m_phase, d, win);
    v[3] = chg && d != 7 && !win &&
           (((m_phase == 1 || m_phase == 3) && m_dwell < GREEN_MIN) ||
            ((m_phase == 2 || m_phase == 4) && m_dwell < YELLOW_MIN));
    v[4] = !chg && !em && !m_stuck_done && (m_dwell + 1 >= MAX_DWELL);
    code = 0;
    for (int i = 4; i >= 0; i--) if (v[i]) code = i + 1;
    if (m_phase == 0 && d == 1 && !win) m_rounds = (m_rounds + 1) % 256;
    if (chg) begin
      m_dwell = 1;
      m_stuck_done = 0;
    end else begin
      if (m_dwell < 255) m_dwell++;
      if (v[4]) m_stuck_done = 1;
    end
    for (int i = 0; i < 5; i++) m_err[i] = v[i] || (m_err[i] && !clr);
    if (m_first == 0 || clr) m_first = code;
    m_viol = (code != 0);
    m_em2 = m_em1;
    m_em1 = em;
    m_phase = d;
  endtask

  task automatic compareHead();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("phase", phase, e.ph);
      checkOutput("dwell", dwell, e.dw);
      checkOutput("rounds", rounds, e.rd);
      checkOutput("err_flags", obsErrs(), e.er);
      checkOutput("err_first", err_first, e.fi);
      checkOutput("viol", viol, e.vi);
    end
  endtask

  task automatic driveLamps(input logic [5:0] l);
    {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} = l;
  endtask

  // Hold a lamp pattern for n cycles, scoreboarding each sample
  task automatic applyStimulus(input logic [5:0] l, input bit em, input bit clr, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compareHead();
      rst_n = 1'b1;
      driveLamps(l);
      emergency_vehicle = em;
      clr_err = clr;
      modelStep(l, em, clr);
      sb.push_back(modelSnapshot());
    end
  endtask

  task automatic applyReset(input int n, input logic [5:0] l);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compareHead();
      rst_n = 1'b0;
      driveLamps(l);
      emergency_vehicle = 1'b0;
      clr_err = 1'b0;
      modelReset();
      sb.push_back(modelSnapshot());
    end
  endtask

  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    driveLamps(ALL_R);
    emergency_vehicle = 1'b0;
    clr_err = 1'b0;
    modelReset();

    $display("[TB] reset");
    applyReset(2, ALL_R);
    peek();
    checkOutput("rst_phase", phase, 0);
    checkOutput("rst_dwell", dwell, 1);
    checkOutput("rst_rounds", rounds, 0);
    checkOutput("rst_errs", obsErrs(), 0);
    checkOutput("rst_first", err_first, 0);
    checkOutput("rst_viol", viol, 0);

    $display("[TB] legal cycles");
    for (int r = 0; r < 2; r++) begin
      applyStimulus(NS_G, 0, 0, 9);
      peek();
      checkOutput("ns_go_dwell9", dwell, 9);
      applyStimulus(NS_Y, 0, 0, 4);
      applyStimulus(ALL_R, 0, 0, 1);
      applyStimulus(EW_G, 0, 0, 9);
      peek();
      checkOutput("ew_go_dwell9", dwell, 9);
      applyStimulus(EW_Y, 0, 0, 4);
      applyStimulus(ALL_R, 0, 0, 1);
    end
    peek();
    checkOutput("legal_rounds", rounds, 2);
    checkOutput("legal_errs", obsErrs(), 0);

    $display("[TB] conflict");
    applyStimulus(ALL_R, 0, 0, 2);
    applyStimulus(BOTH_G, 0, 0, 1);
    peek();
    checkOutput("conf_errs", obsErrs(), 5'b00001);
    checkOutput("conf_first", err_first, 1);
    checkOutput("conf_viol", viol, 1);
    checkOutput("conf_phase", phase, 7);
    applyStimulus(ALL_R, 0, 0, 2);
    peek();
    checkOutput("conf_viol_once", viol, 0);
    applyStimulus(ALL_R, 0, 1, 1);
    peek();
    checkOutput("clr1_errs", obsErrs(), 0);
    checkOutput("clr1_first", err_first, 0);

    $display("[TB] short green");
    applyStimulus(NS_G, 0, 0, 5);
    applyStimulus(NS_Y, 0, 0, 1);
    peek();
    checkOutput("short_errs", obsErrs(), 5'b01000);
    checkOutput("short_first", err_first, 4);
    applyStimulus(NS_Y, 0, 0, 3);
    applyStimulus(ALL_R, 0, 1, 1);
    applyStimulus(NS_G, 0, 0, 4);
    applyStimulus(NS_G, 1, 0, 1);
    applyStimulus(NS_Y, 0, 0, 4);
    applyStimulus(ALL_R, 0, 0, 1);
    peek();
    checkOutput("short_em_errs", obsErrs(), 0);

    $display("[TB] sequence");
    applyStimulus(NS_G, 0, 0, 9);
    applyStimulus(NS_Y, 0, 0, 4);
    applyStimulus(EW_G, 0, 0, 1);
    peek();
    checkOutput("seq_errs", obsErrs(), 5'b00100);
    checkOutput("seq_first", err_first, 3);
    applyStimulus(EW_G, 0, 0, 8);
    applyStimulus(EW_Y, 0, 1, 1);
    applyStimulus(EW_Y, 0, 0, 2);
    applyStimulus(EW_Y, 1, 0, 1);
    applyStimulus(NS_G, 0, 0, 1);
    applyStimulus(ALL_R, 0, 0, 1);
    peek();
    checkOutput("preempt_errs", obsErrs(), 0);
    checkOutput("preempt_first", err_first, 0);
    applyStimulus(ALL_R, 0, 0, 2);

    $display("[TB] stuck");
    applyStimulus(EW_G, 0, 0, 63);
    peek();
    checkOutput("stuck_pre", obsErrs(), 0);
    applyStimulus(EW_G, 0, 0, 1);
    peek();
    checkOutput("stuck_errs", obsErrs(), 5'b10000);
    checkOutput("stuck_dwell", dwell, 64);
    checkOutput("stuck_viol", viol, 1);
    checkOutput("stuck_first", err_first, 5);
    applyStimulus(EW_G, 0, 0, 6);
    peek();
    checkOutput("stuck_dwell70", dwell, 70);
    checkOutput("stuck_viol_once", viol, 0);
    applyStimulus(EW_G, 0, 1, 1);
    peek();
    checkOutput("clr2_errs", obsErrs(), 0);
    checkOutput("clr2_first", err_first, 0);
    applyStimulus(EW_Y, 0, 0, 4);
    applyStimulus(ALL_R, 0, 0, 1);

    $display("[TB] reset mid-sequence");
    applyStimulus(NS_G, 0, 0, 3);
    applyReset(2, NS_RY);
    peek();
    checkOutput("mrst_errs", obsErrs(), 0);
    checkOutput("mrst_phase", phase, 0);
    checkOutput("mrst_dwell", dwell, 1);
    checkOutput("mrst_rounds", rounds, 0);
    applyStimulus(ALL_R, 0, 0, 1);
    peek();
    checkOutput("post_rst_phase", phase, 0);
    checkOutput("post_rst_dwell", dwell, 2);
    checkOutput("post_rst_viol", viol, 0);
    applyStimulus(ALL_R, 0, 0, 2);

    @(negedge clk);
    compareHead();
    if (sb.size() != 0) checkOutput("sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
